// File: rtl/pc_next_ctrl_if.sv
// pc_next_ctrl_if: groups the PC-register, decode, ALU-flag and next-PC
// signals between the decode/execute logic (master) and the next-PC
// control stage (slave).
interface pc_next_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9
);
    // Toward the next-PC stage
    logic [PC_W-1:0]  pc_q;
    logic             imem_rdy;
    logic             is_b;
    logic             is_br;
    logic             is_hlt;
    logic [2:0]       cond;
    logic [IMM_W-1:0] imm;
    logic [PC_W-1:0]  br_tgt;
    logic             alu_n;
    logic             alu_z;
    logic             alu_v;
    logic [2:0]       flag_wen;

    // From the next-PC stage
    logic [PC_W-1:0]  pc_d;
    logic             pc_wen;
    logic [PC_W-1:0]  pc_plus2;
    logic             instr_commit;
    logic             halted;
    logic [2:0]       flags;

    modport master (
        output pc_q, imem_rdy, is_b, is_br, is_hlt, cond, imm, br_tgt,
               alu_n, alu_z, alu_v, flag_wen,
        input  pc_d, pc_wen, pc_plus2, instr_commit, halted, flags
    );

    modport slave (
        input  pc_q, imem_rdy, is_b, is_br, is_hlt, cond, imm, br_tgt,
               alu_n, alu_z, alu_v, flag_wen,
        output pc_d, pc_wen, pc_plus2, instr_commit, halted, flags
    );
endinterface

// File: rtl/pc_next_ctrl.sv
// pc_next_ctrl: next-PC selection, N/Z/V flag register, branch condition
// evaluation and a RUN/WAIT/HALT sequencer that stalls on instruction
// memory and freezes the PC on HLT.
// Optional build macro PC_TRACE_EN adds retire_cnt / taken_cnt counters.
// rst is synchronous and active-low.
module pc_next_ctrl #(
    parameter int PC_W   = 16,
    parameter int PC_INC = 2,
    parameter int IMM_W  = 9
) (
    input  logic          clk,
    input  logic          rst,
    pc_next_ctrl_if.slave bus
`ifdef PC_TRACE_EN
    ,
    output logic [15:0]   retire_cnt,
    output logic [15:0]   taken_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      flags_q, flags_d;
    logic [2:0]      alu_bits;
    logic [PC_W-1:0] pc_plus2_c;
    logic [PC_W-1:0] b_off;
    logic [PC_W-1:0] b_tgt;
    logic            cond_taken;
    logic            branch_sel;
    logic            commit_c;
    logic            wen_c;

    assign alu_bits = {bus.alu_n, bus.alu_z, bus.alu_v};

    // Sequential address and PC-relative target (offset is in halfwords)
    always_comb begin
        pc_plus2_c = bus.pc_q + PC_W'(PC_INC);
        b_off      = {{(PC_W-IMM_W-1){bus.imm[IMM_W-1]}}, bus.imm, 1'b0};
        b_tgt      = pc_plus2_c + b_off;
    end

    // Branch condition from the registered flags {N,Z,V}
    always_comb begin
        cond_taken = 1'b0;
        case (bus.cond)
            3'b000:  cond_taken = ~flags_q[1];
            3'b001:  cond_taken = flags_q[1];
            3'b010:  cond_taken = ~flags_q[1] & ~flags_q[2];
            3'b011:  cond_taken = flags_q[2];
            3'b100:  cond_taken = flags_q[1] | (~flags_q[1] & ~flags_q[2]);
            3'b101:  cond_taken = flags_q[2] | flags_q[1];
            3'b110:  cond_taken = flags_q[0];
            default: cond_taken = 1'b1;
        endcase
    end

    // Next-PC mux: HLT holds the PC, then BR, then B, then sequential
    always_comb begin
        branch_sel = 1'b0;
        if (bus.is_hlt) begin
            bus.pc_d = bus.pc_q;
        end else if (bus.is_br && cond_taken) begin
            bus.pc_d   = bus.br_tgt;
            branch_sel = 1'b1;
        end else if (bus.is_b && cond_taken) begin
            bus.pc_d   = b_tgt;
            branch_sel = 1'b1;
        end else begin
            bus.pc_d = pc_plus2_c;
        end
    end

    // Sequencer next state and strobes; WAIT behaves like RUN once ready
    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
        wen_c    = 1'b0;
        case (state_q)
            ST_RUN, ST_WAIT: begin
                if (bus.imem_rdy) begin
                    commit_c = 1'b1;
                    if (bus.is_hlt) begin
                        state_d = ST_HALT;
                    end else begin
                        wen_c   = 1'b1;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
        if (!rst) begin
            state_d  = ST_RUN;
            commit_c = 1'b0;
            wen_c    = 1'b0;
        end
    end

    // Per-flag load: only a retiring instruction may update a flag
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag
            always_comb begin
                flags_d[gi] = (commit_c && bus.flag_wen[gi]) ? alu_bits[gi]
                                                             : flags_q[gi];
            end
        end
    endgenerate

    // State and flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    assign bus.pc_plus2     = pc_plus2_c;
    assign bus.pc_wen       = wen_c;
    assign bus.instr_commit = commit_c;
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.flags        = flags_q;

`ifdef PC_TRACE_EN
    logic [15:0] retire_cnt_q, retire_cnt_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    // Retire / taken-branch counters, naturally frozen in HALT (no commits)
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (commit_c) begin
            retire_cnt_d = retire_cnt_q + 16'd1;
            if (branch_sel) begin
                taken_cnt_d = taken_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            retire_cnt_q <= 16'd0;
            taken_cnt_q  <= 16'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign taken_cnt  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_next_ctrl.sv
// tb_pc_next_ctrl: directed stimulus for pc_next_ctrl with an abstract
// reference model (flags, halted, counters) checked every cycle, plus
// hand-computed literal expectations. Honours PC_TRACE_EN.
module tb_pc_next_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_next_ctrl_if #(.PC_W(16), .IMM_W(9)) u_if ();

    logic        fb;
    logic [15:0] pc_r;
    logic [15:0] pc_force;
    assign u_if.pc_q = fb ? pc_r : pc_force;

`ifdef PC_TRACE_EN
    logic [15:0] retire_cnt;
    logic [15:0] taken_cnt;
`endif

    pc_next_ctrl #(.PC_W(16), .PC_INC(2), .IMM_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
`ifdef PC_TRACE_EN
        ,
        .retire_cnt (retire_cnt),
        .taken_cnt  (taken_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // PC register modelled in the bench for the sequential test
    always @(posedge clk) begin
        if (fb && u_if.pc_wen) pc_r <= u_if.pc_d;
    end

    // Reference model state
    logic        model_ok = 1'b0;
    logic [2:0]  flags_m  = 3'b000;   // {N,Z,V}
    logic        halted_m = 1'b0;
    int          ret_m    = 0;
    int          tak_m    = 0;

    function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
        logic n, z, v;
        n = f[2]; z = f[1]; v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] exp_next(input logic [2:0] f);
        int t;
        logic tk;
        tk = cond_ok(u_if.cond, f);
        if (u_if.is_hlt) return u_if.pc_q;
        if (u_if.is_br && tk) return u_if.br_tgt;
        if (u_if.is_b && tk) begin
            t = int'(u_if.pc_q) + 2 + 2 * int'($signed(u_if.imm));
            return t[15:0];
        end
        t = int'(u_if.pc_q) + 2;
        return t[15:0];
    endfunction

    function automatic logic exp_taken_sel(input logic [2:0] f);
        return !u_if.is_hlt && (u_if.is_b || u_if.is_br) && cond_ok(u_if.cond, f);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge
    always @(posedge clk) begin
        if (!rst) begin
            model_ok = 1'b1;
            flags_m  = 3'b000;
            halted_m = 1'b0;
            ret_m    = 0;
            tak_m    = 0;
        end else if (model_ok && !halted_m && u_if.imem_rdy) begin
            if (exp_taken_sel(flags_m)) tak_m = (tak_m + 1) % 65536;
            ret_m = (ret_m + 1) % 65536;
            if (u_if.flag_wen[2]) flags_m[2] = u_if.alu_n;
            if (u_if.flag_wen[1]) flags_m[1] = u_if.alu_z;
            if (u_if.flag_wen[0]) flags_m[0] = u_if.alu_v;
            if (u_if.is_hlt) halted_m = 1'b1;
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        logic exp_commit, exp_wen;
        int   p2;
        if (model_ok) begin
            exp_commit = rst && !halted_m && u_if.imem_rdy;
            exp_wen    = exp_commit && !u_if.is_hlt;
            p2         = int'(u_if.pc_q) + 2;
            check("m_pc_plus2", u_if.pc_plus2, p2[15:0]);
            check("m_pc_d", u_if.pc_d, exp_next(flags_m));
            check("m_pc_wen", u_if.pc_wen, exp_wen);
            check("m_commit", u_if.instr_commit, exp_commit);
            check("m_halted", u_if.halted, halted_m);
            check("m_flags", u_if.flags, flags_m);
`ifdef PC_TRACE_EN
            check("m_retire_cnt", retire_cnt, ret_m);
            check("m_taken_cnt", taken_cnt, tak_m);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.imem_rdy = 1'b0;
        u_if.is_b     = 1'b0;
        u_if.is_br    = 1'b0;
        u_if.is_hlt   = 1'b0;
        u_if.cond     = 3'd0;
        u_if.imm      = 9'd0;
        u_if.br_tgt   = 16'd0;
        u_if.alu_n    = 1'b0;
        u_if.alu_z    = 1'b0;
        u_if.alu_v    = 1'b0;
        u_if.flag_wen = 3'b000;
    endtask

    // Trace segment vectors: 5 commits (2 taken), then HLT
    logic tr_b   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic tr_br  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic tr_hlt [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst      = 1'b0;
        fb       = 1'b1;
        pc_r     = 16'h0000;
        pc_force = 16'h0000;
        idle_inputs();

        // Reset cycle: strobes forced low even with imem_rdy high
        step();
        u_if.imem_rdy = 1'b1;
        #1;
        check("rst_pc_wen", u_if.pc_wen, 1'b0);
        check("rst_commit", u_if.instr_commit, 1'b0);

        // Sequential fetch from PC register starting at 0x0000
        step();
        rst = 1'b1;
        #1;
        check("rst_halted", u_if.halted, 1'b0);
        check("rst_flags", u_if.flags, 3'b000);
        check("seq0_pc_d", u_if.pc_d, 16'h0002);
        check("seq0_wen", u_if.pc_wen, 1'b1);
        step();
        check("seq1_pc_d", u_if.pc_d, 16'h0004);
        step();
        check("seq2_pc_d", u_if.pc_d, 16'h0006);
        check("seq2_wen", u_if.pc_wen, 1'b1);

        // Load Z=1 only
        step();
        fb            = 1'b0;
        pc_force      = 16'h0100;
        u_if.flag_wen = 3'b010;
        u_if.alu_z    = 1'b1;
        u_if.alu_n    = 1'b1;
        #1;
        check("zset_commit", u_if.instr_commit, 1'b1);

        // B taken (EQ) and not taken (NE)
        step();
        u_if.flag_wen = 3'b000;
        u_if.alu_z    = 1'b0;
        u_if.alu_n    = 1'b0;
        pc_force      = 16'h0010;
        u_if.is_b     = 1'b1;
        u_if.cond     = 3'b001;
        u_if.imm      = 9'h1FE;
        #1;
        check("flags_z", u_if.flags, 3'b010);
        check("b_eq_pc_d", u_if.pc_d, 16'h000E);
        step();
        u_if.cond = 3'b000;
        #1;
        check("b_ne_pc_d", u_if.pc_d, 16'h0012);

        // BR beats B
        step();
        pc_force    = 16'h0040;
        u_if.is_br  = 1'b1;
        u_if.cond   = 3'b111;
        u_if.br_tgt = 16'h1234;
        #1;
        check("br_pc_d", u_if.pc_d, 16'h1234);

        // Sequential wrap
        step();
        u_if.is_b  = 1'b0;
        u_if.is_br = 1'b0;
        u_if.cond  = 3'b000;
        pc_force   = 16'hFFFE;
        #1;
        check("wrap_plus2", u_if.pc_plus2, 16'h0000);
        check("wrap_pc_d", u_if.pc_d, 16'h0000);

        // Stall 3 cycles with flag writes requested
        step();
        pc_force      = 16'h0020;
        u_if.imem_rdy = 1'b0;
        u_if.flag_wen = 3'b111;
        u_if.alu_n    = 1'b1;
        u_if.alu_z    = 1'b0;
        u_if.alu_v    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_wen", u_if.pc_wen, 1'b0);
            step();
        end
        u_if.imem_rdy = 1'b1;
        u_if.flag_wen = 3'b000;
        #1;
        check("stall_flags", u_if.flags, 3'b010);
        check("stall_end_pc_d", u_if.pc_d, 16'h0022);
        check("stall_end_wen", u_if.pc_wen, 1'b1);

        // HLT with a taken branch present
        step();
        pc_force    = 16'h0030;
        u_if.is_hlt = 1'b1;
        u_if.is_b   = 1'b1;
        u_if.cond   = 3'b111;
        u_if.imm    = 9'h004;
        #1;
        check("hlt_commit", u_if.instr_commit, 1'b1);
        check("hlt_wen", u_if.pc_wen, 1'b0);
        check("hlt_pc_d", u_if.pc_d, 16'h0030);
        for (int i = 0; i < 3; i++) begin
            step();
            u_if.is_hlt   = 1'b0;
            u_if.flag_wen = 3'b111;
            #1;
            check("halt_halted", u_if.halted, 1'b1);
            check("halt_wen", u_if.pc_wen, 1'b0);
            check("halt_commit", u_if.instr_commit, 1'b0);
            check("halt_flags", u_if.flags, 3'b010);
        end

        // Reset out of HALT
        step();
        rst = 1'b0;
        #1;
        check("rst2_wen", u_if.pc_wen, 1'b0);
        step();
        rst = 1'b1;
        idle_inputs();
        u_if.imem_rdy = 1'b1;
        u_if.cond     = 3'b111;
        pc_force      = 16'h0200;
        #1;
        check("rst2_halted", u_if.halted, 1'b0);
        check("rst2_flags", u_if.flags, 3'b000);

        // Five commits with two taken branches, then HLT
        for (int i = 0; i < 6; i++) begin
            u_if.is_b   = tr_b[i];
            u_if.is_br  = tr_br[i];
            u_if.is_hlt = tr_hlt[i];
            u_if.br_tgt = 16'h0300;
            #1;
            step();
        end
        idle_inputs();
        u_if.imem_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("tr_halted", u_if.halted, 1'b1);
`ifdef PC_TRACE_EN
            check("tr_retire", retire_cnt, 16'd6);
            check("tr_taken", taken_cnt, 16'd2);
`endif
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
